// File: rtl/float_to_int_param.sv
// IEEE-754 to integer converter, one operand at a time.
// Bit-serial alignment, RNE or truncating rounding, saturating pack.
module float_to_int_param #(
  parameter int EW         = 11,
  parameter int MW         = 52,
  parameter int IW         = 64,
  parameter int SIGNED_OUT = 1,
  parameter int ROUND_MODE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [EW+MW:0]   input_a,
  input  logic             input_a_stb,
  output logic             input_a_ack,
  output logic [IW-1:0]    output_z,
  output logic             output_z_stb,
  input  logic             output_z_ack,
  output logic [2:0]       output_flags
);

  localparam int FW = 1 + EW + MW;
  localparam int WW = IW + 1 + MW;
  localparam int CW = $clog2(IW + 2) + 1;

  localparam logic [2:0] GET_A   = 3'd0;
  localparam logic [2:0] UNPACK  = 3'd1;
  localparam logic [2:0] SPECIAL = 3'd2;
  localparam logic [2:0] ALIGN   = 3'd3;
  localparam logic [2:0] ROUND   = 3'd4;
  localparam logic [2:0] PACK    = 3'd5;
  localparam logic [2:0] PUT_Z   = 3'd6;

  localparam logic [EW+1:0] BIAS =
    {3'b000, {(EW-1){1'b1}}};

  localparam logic [IW-1:0] S_MAX =
    {1'b0, {(IW-1){1'b1}}};
  localparam logic [IW-1:0] S_MIN =
    {1'b1, {(IW-1){1'b0}}};
  localparam logic [IW-1:0] U_MAX =
    {IW{1'b1}};
  localparam logic [IW:0] LIM =
    {2'b01, {(IW-1){1'b0}}};
  localparam logic [IW:0] TOP =
    {1'b1, {IW{1'b0}}};

  logic [2:0]      state;
  logic            live;
  logic [FW-1:0]   a_q;
  logic            sign;
  logic [EW+1:0]   e;
  logic [MW:0]     mant;
  logic [WW-1:0]   work;
  logic            sticky;
  logic [CW-1:0]   cnt;
  logic [IW:0]     rmag;
  logic            inexact;

  logic [EW-1:0]   a_exp;
  logic [MW-1:0]   a_frac;
  logic            a_sign;
  logic            exp_ones;
  logic            exp_zero;
  logic            frac_nz;

  assign a_sign = a_q[FW-1];
  assign a_exp  = a_q[FW-2 -: EW];
  assign a_frac = a_q[MW-1:0];

  assign exp_ones = &a_exp;
  assign exp_zero = ~|a_exp;
  assign frac_nz  = |a_frac;

  logic signed [31:0] e32;
  logic signed [31:0] s_raw;
  logic [CW-1:0]      s_clamp;
  logic               e_big;

  assign e32   = {{(30-EW){e[EW+1]}}, e};
  assign s_raw = IW - 1 - e32;
  assign e_big = e32 >= IW;

  always_comb begin
    s_clamp = '0;
    if (s_raw < 0)
      s_clamp = '0;
    else if (s_raw > IW + 1)
      s_clamp = CW'(IW + 1);
    else
      s_clamp = CW'(s_raw);
  end

  logic is_nan;
  logic is_ovf;
  logic is_sub;
  logic is_norm;

  assign is_nan  = exp_ones & frac_nz;
  assign is_ovf  = (exp_ones & ~frac_nz) |
                   (~exp_ones & e_big);
  assign is_sub  = exp_zero;
  assign is_norm = ~exp_ones & ~e_big &
                   ~exp_zero;

  logic [IW-1:0] sat_z;

  always_comb begin
    sat_z = '0;
    if (SIGNED_OUT != 0)
      sat_z = sign ? S_MIN : S_MAX;
    else
      sat_z = sign ? '0 : U_MAX;
  end

  logic [IW-1:0] mag;
  logic          g;
  logic [MW-1:0] low;
  logic          st;
  logic          inc;

  assign mag = work[WW-1 -: IW];
  assign g   = work[WW-1-IW];
  assign low = work[MW-1:0];
  assign st  = sticky | (|low);
  assign inc = (ROUND_MODE == 1) && g &&
               (st || mag[0]);

  logic [IW-1:0] neg;
  logic [IW-1:0] pack_z;
  logic [2:0]    pack_f;

  assign neg = ~rmag[IW-1:0] + 1'b1;

  // Signed range is asymmetric: +2^(IW-1) overflows, -2^(IW-1) fits.
  always_comb begin
    pack_z = '0;
    pack_f = '0;
    if (SIGNED_OUT != 0) begin
      if (rmag > LIM || (rmag == LIM && !sign)) begin
        pack_z = sign ? S_MIN : S_MAX;
        pack_f = 3'b010;
      end else begin
        pack_z = sign ? neg : rmag[IW-1:0];
        pack_f = {2'b00, inexact};
      end
    end else begin
      if (sign) begin
        pack_z = '0;
        if (rmag != '0)
          pack_f = 3'b100;
        else
          pack_f = {2'b00, inexact};
      end else if (rmag >= TOP) begin
        pack_z = U_MAX;
        pack_f = 3'b010;
      end else begin
        pack_z = rmag[IW-1:0];
        pack_f = {2'b00, inexact};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      live         <= 1'b0;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      output_flags <= '0;
      a_q          <= '0;
      sign         <= 1'b0;
      e            <= '0;
      mant         <= '0;
      work         <= '0;
      sticky       <= 1'b0;
      cnt          <= '0;
      rmag         <= '0;
      inexact      <= 1'b0;
    end else begin
      live <= 1'b1;
      unique case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a_q         <= input_a;
            input_a_ack <= 1'b0;
            state       <= UNPACK;
          end else if (live) begin
            input_a_ack <= 1'b1;
          end
        end
        UNPACK: begin
          sign  <= a_sign;
          e     <= {2'b00, a_exp} - BIAS;
          mant  <= {1'b1, a_frac};
          state <= SPECIAL;
        end
        SPECIAL: begin
          unique case (1'b1)
            is_nan: begin
              output_z     <= (SIGNED_OUT != 0) ?
                              S_MIN : '0;
              output_flags <= 3'b100;
              output_z_stb <= 1'b1;
              state        <= PUT_Z;
            end
            is_ovf: begin
              output_z     <= sat_z;
              output_flags <= 3'b010;
              output_z_stb <= 1'b1;
              state        <= PUT_Z;
            end
            is_sub: begin
              output_z     <= '0;
              output_flags <= {2'b00, frac_nz};
              output_z_stb <= 1'b1;
              state        <= PUT_Z;
            end
            is_norm: begin
              work   <= {mant, {IW{1'b0}}};
              sticky <= 1'b0;
              cnt    <= s_clamp;
              state  <= (s_clamp == '0) ?
                        ROUND : ALIGN;
            end
            default: state <= GET_A;
          endcase
        end
        ALIGN: begin
          work   <= work >> 1;
          sticky <= sticky | work[0];
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= ROUND;
        end
        ROUND: begin
          rmag    <= {1'b0, mag} +
                     {{IW{1'b0}}, inc};
          inexact <= g | st;
          state   <= PACK;
        end
        PACK: begin
          output_z     <= pack_z;
          output_flags <= pack_f;
          output_z_stb <= 1'b1;
          state        <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            state        <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end

endmodule

// File: tb/tb_float_to_int_param.sv
// Bench for float_to_int_param: directed vectors plus random
// operands against an arithmetic reference, three configurations.
module tb_float_to_int_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] a0, a1;
  logic [31:0] a2;
  logic as0, as1, as2;
  logic ak0, ak1, ak2;
  logic zs0, zs1, zs2;
  logic za0, za1, za2;
  logic [63:0] zo0, zo1;
  logic [31:0] zo2;
  logic [2:0] fl0, fl1, fl2;

  int n_chk = 0;
  int n_fail = 0;

  float_to_int_param #(
    .EW(11), .MW(52), .IW(64),
    .SIGNED_OUT(1), .ROUND_MODE(1)
  ) dut0 (
    .clk(clk), .rst(rst),
    .input_a(a0), .input_a_stb(as0),
    .input_a_ack(ak0),
    .output_z(zo0), .output_z_stb(zs0),
    .output_z_ack(za0),
    .output_flags(fl0)
  );

  float_to_int_param #(
    .EW(11), .MW(52), .IW(64),
    .SIGNED_OUT(1), .ROUND_MODE(0)
  ) dut1 (
    .clk(clk), .rst(rst),
    .input_a(a1), .input_a_stb(as1),
    .input_a_ack(ak1),
    .output_z(zo1), .output_z_stb(zs1),
    .output_z_ack(za1),
    .output_flags(fl1)
  );

  float_to_int_param #(
    .EW(8), .MW(23), .IW(32),
    .SIGNED_OUT(0), .ROUND_MODE(1)
  ) dut2 (
    .clk(clk), .rst(rst),
    .input_a(a2), .input_a_stb(as2),
    .input_a_ack(ak2),
    .output_z(zo2), .output_z_stb(zs2),
    .output_z_ack(za2),
    .output_flags(fl2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               tag, got, want);
    end
  endtask

  function automatic logic ack_of(input int k);
    case (k)
      0: return ak0;
      1: return ak1;
      default: return ak2;
    endcase
  endfunction

  function automatic logic stb_of(input int k);
    case (k)
      0: return zs0;
      1: return zs1;
      default: return zs2;
    endcase
  endfunction

  function automatic logic [63:0] z_of(input int k);
    case (k)
      0: return zo0;
      1: return zo1;
      default: return {32'h0, zo2};
    endcase
  endfunction

  function automatic logic [2:0] flg_of(input int k);
    case (k)
      0: return fl0;
      1: return fl1;
      default: return fl2;
    endcase
  endfunction

  task automatic drive(input int k,
                       input logic [63:0] a,
                       input logic s);
    case (k)
      0: begin a0 = a; as0 = s; end
      1: begin a1 = a; as1 = s; end
      default: begin a2 = a[31:0]; as2 = s; end
    endcase
  endtask

  task automatic zack(input int k, input logic v);
    case (k)
      0: za0 = v;
      1: za1 = v;
      default: za2 = v;
    endcase
  endtask

  // Reference: value = mant * 2^(e-mw), rounded with plain integers.
  function automatic logic [66:0] model(
    input logic [63:0] a, input int ew,
    input int mw, input int iw,
    input int so, input int rm);
    logic [191:0] mant, ip, rem, half;
    logic [191:0] lim, top, mask, zz;
    logic [63:0] frac;
    logic sgn, inx;
    int expf, maxe, e, sh;
    sgn  = a[ew+mw];
    frac = a & ((64'd1 << mw) - 1);
    expf = int'((a >> mw) & ((64'd1 << ew) - 1));
    maxe = (1 << ew) - 1;
    e    = expf - ((1 << (ew - 1)) - 1);
    top  = 192'd1 << iw;
    mask = top - 1;
    lim  = 192'd1 << (iw - 1);
    if (expf == maxe && frac != 0) begin
      zz = (so != 0) ? lim : 192'd0;
      return {3'b100, zz[63:0]};
    end
    if (expf == maxe || e >= iw) begin
      if (so != 0) zz = sgn ? lim : lim - 1;
      else zz = sgn ? 192'd0 : mask;
      return {3'b010, zz[63:0]};
    end
    if (expf == 0)
      return {2'b00, frac != 0, 64'd0};
    mant = {128'd0, frac} | (192'd1 << mw);
    inx = 1'b0;
    rem = '0;
    half = '0;
    if (e < -2) begin
      ip = '0;
      inx = 1'b1;
    end else if (e >= mw) begin
      ip = mant << (e - mw);
    end else begin
      sh = mw - e;
      ip = mant >> sh;
      rem = mant & ((192'd1 << sh) - 1);
      half = 192'd1 << (sh - 1);
      inx = rem != 0;
      if (rm == 1 && (rem > half ||
          (rem == half && ip[0])))
        ip = ip + 1;
    end
    if (so != 0) begin
      if (ip > lim || (ip == lim && !sgn)) begin
        zz = sgn ? lim : lim - 1;
        return {3'b010, zz[63:0]};
      end
      zz = sgn ? ((top - ip) & mask) : ip;
      return {2'b00, inx, zz[63:0]};
    end
    if (sgn)
      return (ip != 0) ? {3'b100, 64'd0}
                       : {2'b00, inx, 64'd0};
    if (ip >= top)
      return {3'b010, mask[63:0]};
    return {2'b00, inx, ip[63:0]};
  endfunction

  function automatic int exp_lat(
    input logic [63:0] a, input int ew,
    input int mw, input int iw);
    int expf, e, s;
    expf = int'((a >> mw) & ((64'd1 << ew) - 1));
    e = expf - ((1 << (ew - 1)) - 1);
    if (expf == (1 << ew) - 1 || expf == 0 ||
        e >= iw)
      return 3;
    s = iw - 1 - e;
    if (s < 0) s = 0;
    if (s > iw + 1) s = iw + 1;
    return 5 + s;
  endfunction

  function automatic logic [63:0] gen(
    input int ew, input int mw,
    input int emin, input int emax);
    logic [63:0] r, frac, sgn;
    int bias, maxe, expf, k;
    bias = (1 << (ew - 1)) - 1;
    maxe = (1 << ew) - 1;
    r = {$urandom, $urandom};
    frac = r & ((64'd1 << mw) - 1);
    if ($urandom_range(0, 2) == 0) begin
      k = int'($urandom_range(0, mw));
      frac = frac & ~((64'd1 << k) - 1);
    end
    case ($urandom_range(0, 11))
      0: expf = maxe;
      1: expf = 0;
      default: expf = bias + emin +
        int'($urandom_range(0, emax - emin));
    endcase
    if (expf == maxe && $urandom_range(0, 1) == 1)
      frac = '0;
    sgn = 64'($urandom_range(0, 1));
    return (sgn << (ew + mw)) |
           (64'(expf) << mw) | frac;
  endfunction

  // hold < 0: caller keeps output_z_ack high throughout
  task automatic convert(input int k,
                         input logic [63:0] a,
                         input int hold,
                         output logic [63:0] z,
                         output logic [2:0] f,
                         output int lat);
    int n, bad;
    n = 0;
    while (!ack_of(k) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ack_wait", ack_of(k), 1'b1);
    drive(k, a, 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drive(k, a, 1'b0);
    end while (!stb_of(k) && lat < 200);
    chk("stb_wait", stb_of(k), 1'b1);
    chk("ack_vs_stb", ack_of(k), 1'b0);
    z = z_of(k);
    f = flg_of(k);
    bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!stb_of(k) || ack_of(k) ||
          z_of(k) !== z || flg_of(k) !== f)
        bad++;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    if (hold >= 0) zack(k, 1'b1);
    @(negedge clk);
    chk("stb_drop", stb_of(k), 1'b0);
    if (hold >= 0) zack(k, 1'b0);
  endtask

  task automatic run(input int k,
                     input logic [63:0] a,
                     input int hold,
                     input logic [66:0] want,
                     input int lat_want);
    logic [63:0] z;
    logic [2:0] f;
    int lat;
    convert(k, a, hold, z, f, lat);
    chk("z", z, want[63:0]);
    chk("flags", f, want[66:64]);
    chk("latency", lat, lat_want);
  endtask

  task automatic run_d(input int k,
                       input logic [63:0] a,
                       input int hold,
                       input logic [66:0] want);
    if (k == 2) run(k, a, hold, want,
                    exp_lat(a, 8, 23, 32));
    else run(k, a, hold, want,
             exp_lat(a, 11, 52, 64));
  endtask

  logic [63:0] ra;
  int seen;

  initial begin
    a0 = '0; a1 = '0; a2 = '0;
    as0 = 0; as1 = 0; as2 = 0;
    za0 = 0; za1 = 0; za2 = 0;
    #3;
    chk("rst_ack", ak0, 1'b0);
    chk("rst_stb", zs0, 1'b0);
    chk("rst_z", zo0, 64'd0);
    chk("rst_flags", fl0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ack_edge1", ak0, 1'b0);
    @(negedge clk);
    chk("ack_edge2", ak0, 1'b1);

    run_d(0, 64'h3FF8000000000000, 0,
          {3'b001, 64'd2});
    run_d(0, 64'h4004000000000000, 1,
          {3'b001, 64'd2});
    run_d(0, 64'hC008000000000000, 0,
          {3'b000, 64'hFFFFFFFFFFFFFFFD});
    run_d(0, 64'hC3E0000000000000, 0,
          {3'b000, 64'h8000000000000000});
    run_d(0, 64'h43E0000000000000, 0,
          {3'b010, 64'h7FFFFFFFFFFFFFFF});
    run_d(0, 64'h7FF8000000000000, 0,
          {3'b100, 64'h8000000000000000});
    run_d(0, 64'hFFF0000000000000, 0,
          {3'b010, 64'h8000000000000000});
    run_d(0, 64'h0000000000000001, 0,
          {3'b001, 64'd0});
    run_d(0, 64'h8000000000000000, 0,
          {3'b000, 64'd0});
    run_d(0, 64'h3FF8000000000000, 10,
          {3'b001, 64'd2});
    run_d(1, 64'h3FF8000000000000, 0,
          {3'b001, 64'd1});
    run_d(2, 64'h00000000BF800000, 0,
          {3'b100, 64'd0});
    run_d(2, 64'h000000004F800000, 0,
          {3'b010, 64'hFFFFFFFF});
    run_d(2, 64'h000000004F7FFFFF, 0,
          {3'b000, 64'hFFFFFF00});

    za0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ra = gen(11, 52, -3, 66);
      run_d(0, ra, -1,
            model(ra, 11, 52, 64, 1, 1));
    end
    za0 = 1'b0;

    seen = 0;
    while (!ak0 && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    drive(0, 64'h3FF8000000000000, 1'b1);
    @(negedge clk);
    drive(0, 64'h0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_stb", zs0, 1'b0);
    chk("abort_ack", ak0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (zs0) seen++;
    end
    chk("abort_quiet", seen, 0);
    run_d(0, 64'h401C000000000000, 0,
          {3'b000, 64'd7});

    for (int i = 0; i < 150; i++) begin
      ra = gen(11, 52, -5, 68);
      run_d(0, ra, int'($urandom_range(0, 2)),
            model(ra, 11, 52, 64, 1, 1));
    end
    for (int i = 0; i < 60; i++) begin
      ra = gen(11, 52, -3, 66);
      run_d(1, ra, int'($urandom_range(0, 1)),
            model(ra, 11, 52, 64, 1, 0));
    end
    for (int i = 0; i < 100; i++) begin
      ra = gen(8, 23, -4, 34);
      run_d(2, ra, int'($urandom_range(0, 2)),
            model(ra, 8, 23, 32, 0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/float_to_int_param.md
FLOAT_TO_INT_PARAM -- requirements
Module: float_to_int_param

Interface
REQ-001 Parameter EW, default 11: exponent field width of the input float.
REQ-002 Parameter MW, default 52: fraction field width of the input float; the input word is 1+EW+MW bits.
REQ-003 Parameter IW, default 64: output integer width.
REQ-004 Parameter SIGNED_OUT, default 1: 1 = two's-complement result, 0 = unsigned result.
REQ-005 Parameter ROUND_MODE, default 1: 0 = truncate toward zero, 1 = round to nearest, ties to even.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 input_a  input  1+EW+MW  IEEE-754 operand (sign, biased exponent, fraction).
REQ-009 input_a_stb  input  1  operand valid.
REQ-010 input_a_ack  output  1  ready to accept an operand.
REQ-011 output_z  output  IW  converted integer.
REQ-012 output_z_stb  output  1  result valid.
REQ-013 output_z_ack  input  1  consumer accepts the result.
REQ-014 output_flags  output  3  [2] invalid, [1] overflow, [0] inexact; valid with output_z_stb.

Function
REQ-015 States: GET_A, UNPACK, SPECIAL, ALIGN, ROUND, PACK, PUT_Z; one operand in flight; no pipelining.
REQ-016 GET_A: input_a_ack=1 from the cycle after entry; a transfer occurs only on a cycle where input_a_ack and input_a_stb are both 1; on transfer, latch input_a, drop ack next cycle, go to UNPACK.
REQ-017 UNPACK: e = biased exponent - (2^(EW-1)-1), held signed in EW+2 bits; mantissa = {1, fraction}; sign latched; go to SPECIAL.
REQ-018 SPECIAL, exponent all-ones, fraction nonzero (NaN): z = 1 followed by IW-1 zeros if SIGNED_OUT=1, else 0; invalid=1; go to PUT_Z.
REQ-019 SPECIAL, infinity or e >= IW: saturate per REQ-023 with overflow=1; go to PUT_Z.
REQ-020 SPECIAL, exponent field zero: zero gives z=0 with no flags; a denormal gives z=0 with inexact=1 under either rounding mode; go to PUT_Z.
REQ-021 Otherwise go to ALIGN; in ALIGN the working value is the mantissa positioned with e integer bits plus a guard bit and a sticky bit.
REQ-022 ALIGN shifts right one bit per cycle; shifted-out bits OR into sticky; this runs for S = clamp(IW-1-e, 0, IW+1) cycles, then goes to ROUND.
REQ-023 Saturation values: SIGNED_OUT=1 gives +max 2^(IW-1)-1 or -max -2^(IW-1); SIGNED_OUT=0 gives all-ones for positive overflow and 0 for negative input.
REQ-024 ROUND: inexact = guard OR sticky; mode 0 discards both; mode 1 increments when guard=1 and (sticky=1 or LSB=1); the increment carry is kept in IW+1 bits.
REQ-025 PACK, signed: magnitude > 2^(IW-1), or magnitude = 2^(IW-1) with a positive sign, gives +/- saturation with overflow=1, inexact=0; otherwise z is the two's complement of the magnitude when sign=1.
REQ-026 PACK, unsigned: a negative input with a nonzero rounded magnitude gives z=0 with invalid=1; a negative input rounding to 0 gives z=0 with inexact only; a magnitude >= 2^IW saturates with overflow=1.
REQ-027 PACK: -0.0 gives z=0 with no flags.
REQ-028 Latency, normal path: the first output_z_stb cycle is 5+S cycles after the input transfer cycle. Special path: 3 cycles after the input transfer cycle.
REQ-029 PUT_Z: output_z_stb=1 and output_z/output_flags registered from the cycle after entry, held stable until output_z_ack is sampled with stb=1; then stb=0 and the state returns to GET_A.
REQ-030 input_a_ack and output_z_stb are never 1 in the same cycle.
REQ-031 output_z_ack while output_z_stb=0 has no effect; input_a_stb while input_a_ack=0 is ignored.

Reset
REQ-032 While rst=0, asynchronously: state=GET_A, input_a_ack=0, output_z_stb=0, output_z=0, output_flags=0.
REQ-033 Reset asserted mid-conversion aborts the operand; no result is emitted for it.
REQ-034 After rst returns to 1, input_a_ack rises on the second clock edge.

Verification (defaults unless stated)
REQ-035 Rounding: 0x3FF8000000000000 (1.5) -> 2, flags 001. 0x4004000000000000 (2.5) -> 2, flags 001. With ROUND_MODE=0, 1.5 -> 1, flags 001.
REQ-036 Signed results: 0xC008000000000000 (-3.0) -> 0xFFFFFFFFFFFFFFFD, flags 000. 0xC3E0000000000000 (-2^63) -> 0x8000000000000000, flags 000. 0x43E0000000000000 (2^63) -> 0x7FFFFFFFFFFFFFFF, flags 010.
REQ-037 Specials: 0x7FF8000000000000 -> 0x8000000000000000, flags 100. 0xFFF0000000000000 (-inf) -> 0x8000000000000000, flags 010. 0x0000000000000001 -> 0, flags 001. 0x8000000000000000 -> 0, flags 000.
REQ-038 Unsigned, EW=8, MW=23, IW=32, SIGNED_OUT=0: 0xBF800000 (-1.0) -> 0, flags 100. 0x4F800000 (2^32) -> 0xFFFFFFFF, flags 010. 0x4F7FFFFF -> 0xFFFFFF00, flags 000.
REQ-039 Backpressure: output_z_ack held 0 for 10 cycles -> output_z_stb stays 1, output_z and output_flags stay stable, input_a_ack stays 0; back-to-back operands with ack tied to 1 give results in order.
REQ-040 Reset: rst pulsed low during ALIGN of 1.5 -> output_z_stb stays 0 and no result appears; the next operand 7.0 (0x401C000000000000) -> 7, flags 000.
